// File: rtl/result_writeback_sched_if.sv
// Shared SRAM write port bundle: host write request side plus the
// registered write channel owned by the writeback scheduler.
interface result_writeback_sched_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          i_host_req;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_data;
    logic          o_host_gnt;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          i_wr_ready;

    // scheduler side
    modport master (
        input  i_host_req, i_host_addr, i_host_data, i_wr_ready,
        output o_host_gnt, o_wr_en, o_wr_addr, o_wr_data
    );

    // host / SRAM side
    modport slave (
        output i_host_req, i_host_addr, i_host_data, i_wr_ready,
        input  o_host_gnt, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/result_writeback_sched.sv
// Streams a ROWSxCOLS result matrix into the output SRAM, sharing the
// single write port with a host requester under alternating priority.
module result_writeback_sched #(
    parameter  int ROWS = 32,
    parameter  int COLS = 32,
    parameter  int DW   = 16,
    parameter  int AW   = 10,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic          i_mat_valid,
    output logic [RW-1:0] o_rd_row,
    output logic [CW-1:0] o_rd_col,
    input  logic [DW-1:0] i_rd_data,
    output logic          o_busy,
    output logic          o_done,
    result_writeback_sched_if.master wr
);
    localparam int NEL = ROWS * COLS;
    localparam int IW  = $clog2(NEL);
    localparam logic [IW-1:0] LAST = IW'(NEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          host_prio_q, host_prio_d;

    logic slot_free;
    logic strm_cand;
    logic host_cand;
    logic host_ld;
    logic strm_ld;

    assign slot_free = !wr_en_q || wr.i_wr_ready;
    assign strm_cand = (state_q == S_STREAM) && i_mat_valid;
    assign host_cand = wr.i_host_req;

    assign o_rd_row = RW'(idx_q / IW'(COLS));
    assign o_rd_col = CW'(idx_q % IW'(COLS));
    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_DONE);

    assign wr.o_wr_en     = wr_en_q;
    assign wr.o_wr_addr   = wr_addr_q;
    assign wr.o_wr_data   = wr_data_q;
    // grant is a same-cycle handshake; forced low while reset is held
    assign wr.o_host_gnt  = host_ld && i_rst_n;

    // arbitration, write-slot load and sequencing
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        host_prio_d = host_prio_q;
        host_ld     = 1'b0;
        strm_ld     = 1'b0;

        if (slot_free) begin
            wr_en_d = 1'b0;
            if (host_cand && strm_cand) begin
                host_ld     = host_prio_q;
                strm_ld     = !host_prio_q;
                host_prio_d = !host_prio_q;
            end else begin
                host_ld = host_cand;
                strm_ld = strm_cand;
            end
        end

        if (host_ld) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr.i_host_addr;
            wr_data_d = wr.i_host_data;
        end else if (strm_ld) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + AW'(idx_q);
            wr_data_d = i_rd_data;
            idx_d     = idx_q + IW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    idx_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mat_valid) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (strm_ld && idx_q == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (slot_free) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and write-slot registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            host_prio_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            host_prio_q <= host_prio_d;
        end
    end
endmodule
